spi_slave_regif: RTL
====================

# spi_slave_regif

Parametrised SPI slave that bridges an external SPI master onto the internal register bus. It oversamples SCLK, CS and MOSI on the system clock. It supports all four CPOL/CPHA modes, generic address and data widths, and optional burst transfers with address auto-increment. It issues single-cycle write and read strobes toward the register file and raises an error pulse on truncated words.

## Interface
- ADDR_W, 5, address width in bits
- DATA_W, 8, data word width in bits
- CPOL, 0, SCLK idle level
- CPHA, 0, 0: sample on leading edge; 1: sample on trailing edge
- BURST, 1, 1: auto-increment bursts allowed; 0: single word per CS frame
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- SCLK  input  1  SPI clock, asynchronous to clk
- CS  input  1  chip select, active-low, asynchronous
- MOSI  input  1  serial data in, asynchronous
- MISO  output  1  serial data out; 0 whenever not in a read data phase
- Addr  output  ADDR_W  register address
- Data_out  output  DATA_W  write data, valid while Wr=1
- Wr  output  1  one-clk write strobe
- Rd  output  1  one-clk read strobe
- Data_in  input  DATA_W  read data, sampled exactly one clk after Rd
- Busy  output  1  1 while CS frame active (state != IDLE)
- Err  output  1  one-clk pulse: CS rose with partial header/word

## Operation
- Reset: all outputs 0; state IDLE; shift register, bit counter cleared.
- Sync: SCLK, CS, MOSI each through 2 flops; edges detected on synced SCLK. Sample edge = leading (CPHA=0) or trailing (CPHA=1); shift edge = the other one. Leading = rising if CPOL=0, falling if CPOL=1.
- Frame, MSB first: header of 1+ADDR_W bits (first bit R/W, 1=write, 0=read; then address), then DATA_W-bit words.
- States:
  - IDLE: wait synced CS=0 -> HDR; counter=0.
  - HDR: shift MOSI on sample edges. After the last header bit, Addr <= header address. Write -> WDATA. Read -> RFETCH.
  - RFETCH: Rd=1 for one clk. Next clk: shift register <= Data_in -> RDATA.
  - WDATA: shift DATA_W bits. On the last bit: Data_out <= word, Wr=1 for one clk. Then BURST=1: Addr <= Addr+1 (mod 2^ADDR_W), stay. BURST=0 -> DONE.
  - RDATA: MISO <= shift MSB on each shift edge; MOSI ignored. After DATA_W sample edges: BURST=1: Addr+1 -> RFETCH. BURST=0 -> DONE.
  - DONE: ignore SCLK; MISO=0.
- CS rise (synced) in any state -> IDLE next clk; MISO=0. Err=1 if the counter is mid-header or mid-word (nonzero bits of current unit). No Wr for a partial word.
- Simultaneous CS rise and the final sample edge of a word: the edge is processed first (Wr issued), then IDLE; no Err.
- Wrap: Addr = 2^ADDR_W-1 increments to 0.

## Timing
- Synchronizer latency: 2 clk; edge detect +1 clk.
- Required: SCLK high and low phases >= 4 clk each; CS setup to first edge >= 4 clk.
- Wr asserted 1 clk after the detected last sample edge of a word.
- Rd asserted 1 clk after the detected last header (or last read word) sample edge. Data_in captured at Rd+1. First MISO bit valid at the next detected shift edge.
- CPHA=0 read: first data bit shifts out on the trailing edge of the last header bit.
- MISO changes only on detected shift edges or on CS/reset clear.
- rst mid-frame: immediate return to reset values; the frame is abandoned, no Err pulse.

## Test plan
- Mode 0, ADDR_W=5, DATA_W=8: write header 1,0x0A, data 0x5C -> single Wr, Addr=0x0A, Data_out=0x5C; Err=0.
- Mode 3 read, Addr 0x03, Data_in=0xA7 on Rd+1 -> Rd pulse with Addr=0x03; MISO bits 1,0,1,0,0,1,1,1.
- BURST=1, write at 0x1F, data 0x11,0x22,0x33 -> Wr at Addr 0x1F, 0x00, 0x01 with matching data.
- CS rise after 5 bits of the second word -> only first Wr; Err pulses once; Busy falls; MISO=0.
- BURST=0, 16 extra SCLKs after the word -> exactly one Wr/Rd; DONE held until CS high.
- rst asserted mid-read at bit 4 -> next clk all outputs 0; new frame after reset decodes correctly.

Source files
------------

// File: rtl/spi_slave_regif.sv
// spi_slave_regif: SPI slave that oversamples SCLK/CS/MOSI on clk and bridges
// frames of {R/W, address} + data words onto a simple register bus with
// single-cycle Wr/Rd strobes, optional burst auto-increment and an Err pulse
// when a frame is cut short in the middle of a header or word.
module spi_slave_regif #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0,
    parameter int BURST  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Data_out,
    output logic              Wr,
    output logic              Rd,
    input  logic [DATA_W-1:0] Data_in,
    output logic              Busy,
    output logic              Err
);

    localparam int HDR_BITS = ADDR_W + 1;
    localparam int SH_W     = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
    localparam int CNT_W    = $clog2(SH_W + 1);

    localparam logic              SCLK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam logic              SAMPLE_TR = (CPHA != 0) ? 1'b1 : 1'b0;
    localparam logic              BURST_EN  = (BURST != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_RFETCH = 3'd2,
        ST_RCAP   = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic cs_meta_r, cs_sync_r, cs_prev_r;
    logic mosi_meta_r, mosi_sync_r;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [SH_W-1:0]   shift_r, shift_nxt_s;
    logic              miso_r, miso_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [DATA_W-1:0] data_out_r, data_out_nxt_s;
    logic              wr_r, wr_nxt_s;
    logic              rd_r, rd_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              err_r, err_nxt_s;

    logic                sclk_rise_s, sclk_fall_s, lead_s, trail_s;
    logic                sample_s, shift_edge_s, cs_rise_s;
    logic [SH_W-1:0]     shift_in_s;
    logic [HDR_BITS-1:0] hdr_word_s;
    logic [DATA_W-1:0]   dat_word_s;

    assign sclk_rise_s  = sclk_sync_r & ~sclk_prev_r;
    assign sclk_fall_s  = ~sclk_sync_r & sclk_prev_r;
    assign lead_s       = SCLK_IDLE ? sclk_fall_s : sclk_rise_s;
    assign trail_s      = SCLK_IDLE ? sclk_rise_s : sclk_fall_s;
    assign sample_s     = SAMPLE_TR ? trail_s : lead_s;
    assign shift_edge_s = SAMPLE_TR ? lead_s : trail_s;
    assign cs_rise_s    = cs_sync_r & ~cs_prev_r;

    // MOSI travels through the same two-flop depth as SCLK, so the synced
    // bit lines up with the detected sample edge.
    assign shift_in_s = {shift_r[SH_W-2:0], mosi_sync_r};
    assign hdr_word_s = shift_in_s[HDR_BITS-1:0];
    assign dat_word_s = shift_in_s[DATA_W-1:0];

    assign MISO     = miso_r;
    assign Addr     = addr_r;
    assign Data_out = data_out_r;
    assign Wr       = wr_r;
    assign Rd       = rd_r;
    assign Busy     = busy_r;
    assign Err      = err_r;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_r <= SCLK_IDLE;
            sclk_sync_r <= SCLK_IDLE;
            sclk_prev_r <= SCLK_IDLE;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= SCLK;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            cs_meta_r   <= CS;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            mosi_meta_r <= MOSI;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    // Frame FSM: next state, shift/count datapath and registered outputs.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        shift_nxt_s    = shift_r;
        miso_nxt_s     = miso_r;
        data_out_nxt_s = data_out_r;
        wr_nxt_s       = 1'b0;
        rd_nxt_s       = 1'b0;
        err_nxt_s      = 1'b0;
        // Burst writes advance the address once the strobe has been seen.
        if (wr_r && BURST_EN) begin
            addr_nxt_s = addr_r + ADDR_ONE;
        end else begin
            addr_nxt_s = addr_r;
        end

        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s  = CNT_ZERO;
                miso_nxt_s = 1'b0;
                if (!cs_sync_r) begin
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (sample_s) begin
                    shift_nxt_s = shift_in_s;
                    if (cnt_r == HDR_LAST) begin
                        cnt_nxt_s  = CNT_ZERO;
                        addr_nxt_s = hdr_word_s[ADDR_W-1:0];
                        if (hdr_word_s[ADDR_W]) begin
                            state_nxt_s = ST_WDATA;
                        end else begin
                            state_nxt_s = ST_RFETCH;
                            rd_nxt_s    = 1'b1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_RFETCH: begin
                // Rd is high this cycle; the register file answers next cycle.
                state_nxt_s = ST_RCAP;
            end
            ST_RCAP: begin
                shift_nxt_s = SH_W'(Data_in);
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_RDATA;
            end
            ST_RDATA: begin
                if (shift_edge_s) begin
                    miso_nxt_s  = shift_r[DATA_W-1];
                    shift_nxt_s = {shift_r[SH_W-2:0], 1'b0};
                end else begin
                    shift_nxt_s = shift_r;
                end
                if (sample_s) begin
                    if (cnt_r == DATA_LAST) begin
                        cnt_nxt_s = CNT_ZERO;
                        if (BURST_EN) begin
                            addr_nxt_s  = addr_r + ADDR_ONE;
                            state_nxt_s = ST_RFETCH;
                            rd_nxt_s    = 1'b1;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_WDATA: begin
                if (sample_s) begin
                    shift_nxt_s = shift_in_s;
                    if (cnt_r == DATA_LAST) begin
                        cnt_nxt_s      = CNT_ZERO;
                        data_out_nxt_s = dat_word_s;
                        wr_nxt_s       = 1'b1;
                        if (BURST_EN) begin
                            state_nxt_s = ST_WDATA;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_DONE: begin
                cnt_nxt_s  = CNT_ZERO;
                miso_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                miso_nxt_s  = 1'b0;
            end
        endcase

        // CS rise wins over everything except the edge already processed
        // above, so a word completing on the same clk still writes cleanly.
        if (cs_rise_s) begin
            if ((state_r == ST_HDR || state_r == ST_WDATA || state_r == ST_RDATA)
                && (cnt_nxt_s != CNT_ZERO)) begin
                err_nxt_s = 1'b1;
            end else begin
                err_nxt_s = 1'b0;
            end
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            miso_nxt_s  = 1'b0;
            rd_nxt_s    = 1'b0;
        end else begin
            err_nxt_s = 1'b0;
        end

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            shift_r    <= SH_W'(1'b0);
            miso_r     <= 1'b0;
            addr_r     <= ADDR_W'(1'b0);
            data_out_r <= DATA_W'(1'b0);
            wr_r       <= 1'b0;
            rd_r       <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            miso_r     <= miso_nxt_s;
            addr_r     <= addr_nxt_s;
            data_out_r <= data_out_nxt_s;
            wr_r       <= wr_nxt_s;
            rd_r       <= rd_nxt_s;
            busy_r     <= busy_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

endmodule
